// File: rtl/breakout_pkg.sv
// breakout_pkg: shared playfield geometry, brick layout and FSM encoding
// for the breakout game-logic blocks.
package breakout_pkg;
   localparam logic [8:0] X_MIN    = 9'd8;
   localparam logic [8:0] X_MAX    = 9'd311;
   localparam logic [7:0] Y_MIN    = 8'd8;
   localparam logic [7:0] Y_MAX    = 8'd239;
   localparam logic [7:0] PADDLE_Y = 8'd220;
   localparam logic [9:0] PADDLE_W = 10'd32;
   localparam logic [2:0][8:0] BRICK_X = {9'd200, 9'd150, 9'd100};
   localparam logic [7:0] BRICK_Y  = 8'd60;
   localparam logic [8:0] BRICK_W  = 9'd32;
   localparam logic [7:0] BRICK_H  = 8'd4;
   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_TICK,
      S_CHK_WALL,
      S_CHK_PADDLE,
      S_CHK_BRICK0,
      S_CHK_BRICK1,
      S_CHK_BRICK2,
      S_MOVE,
      S_LOST,
      S_DONE
   } state_e;
   function automatic logic in_brick(input logic [8:0] cx, input logic [7:0] cy, input logic [8:0] bx);
      return cx >= bx && cx <= bx + BRICK_W - 9'd1 && cy >= BRICK_Y && cy <= BRICK_Y + BRICK_H - 8'd1;
   endfunction
endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: free-running frame divider; wrap is high during the last
// count so the edge that returns the counter to zero is the tick edge.
module frame_tick_gen #(
   parameter int TICK_DIV = 833333
) (
   input  logic clk,
   input  logic reset,
   output logic wrap
);
   localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      wrap  = cnt_q == W'(TICK_DIV - 1);
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/ball_physics.sv
// ball_physics: once per frame tick, resolves wall, paddle and brick
// collisions in sequence and moves the ball one pixel diagonally.
module ball_physics
   import breakout_pkg::*;
#(
   parameter int TICK_DIV = 833333,
   parameter int BALL_X0  = 160,
   parameter int BALL_Y0  = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       launch,
   input  logic [8:0] paddle_pos,
   output logic [8:0] ball_x,
   output logic [7:0] ball_y,
   output logic       fps,
   output logic       brick_hit,
   output logic [8:0] brick_x,
   output logic [7:0] brick_y,
   output logic [2:0] bricks_alive,
   output logic       miss,
   output logic       cleared
);
   state_e     state_q, state_d;
   logic [8:0] x_q, x_d, bx_q, bx_d, cx;
   logic [7:0] y_q, y_d, by_q, by_d, cy;
   logic       dx_q, dx_d, dy_q, dy_d;  // dx 1 = right, dy 1 = down
   logic       pend_q, pend_d, hit_q, hit_d;
   logic       fps_q, fps_d, brick_hit_q, brick_hit_d, miss_q, miss_d, cleared_q, cleared_d;
   logic [2:0] alive_q, alive_d;
   logic [1:0] bk;
   logic [9:0] paddle_hi;
   logic       brick_now, wrap;

   frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .reset(reset),
      .wrap (wrap)
   );

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      hit_d       = hit_q;
      bx_d        = bx_q;
      by_d        = by_q;
      alive_d     = alive_q;
      fps_d       = 1'b0;
      brick_hit_d = 1'b0;
      miss_d      = 1'b0;
      cleared_d   = cleared_q;
      // a wrap during the exit cycle is impossible, so set simply wins
      pend_d      = wrap | (pend_q & (state_q != S_WAIT_TICK));
      cx          = dx_q ? x_q + 9'd1 : x_q - 9'd1;
      cy          = dy_q ? y_q + 8'd1 : y_q - 8'd1;
      bk          = state_q == S_CHK_BRICK0 ? 2'd0 : state_q == S_CHK_BRICK1 ? 2'd1 : 2'd2;
      paddle_hi   = {1'b0, paddle_pos} + PADDLE_W - 10'd1;
      brick_now   = (state_q inside {S_CHK_BRICK0, S_CHK_BRICK1, S_CHK_BRICK2}) &&
                    alive_q[bk] && !hit_q && in_brick(cx, cy, BRICK_X[bk]);
      if (brick_now) begin
         alive_d[bk] = 1'b0;
         dy_d        = ~dy_q;
         hit_d       = 1'b1;
         bx_d        = BRICK_X[bk];
         by_d        = BRICK_Y;
      end
      case (state_q)
         S_IDLE: if (launch) begin
            dx_d    = 1'b1;
            dy_d    = 1'b0;
            state_d = S_WAIT_TICK;
         end
         S_WAIT_TICK: if (pend_q) begin
            hit_d   = 1'b0;
            state_d = S_CHK_WALL;
         end
         S_CHK_WALL: begin
            if ((!dx_q && x_q == X_MIN) || (dx_q && x_q == X_MAX)) dx_d = ~dx_q;
            if (!dy_q && y_q == Y_MIN) dy_d = 1'b1;
            state_d = S_CHK_PADDLE;
         end
         S_CHK_PADDLE: begin
            state_d = S_CHK_BRICK0;
            if (dy_q && y_q == PADDLE_Y - 8'd1 && x_q >= paddle_pos && {1'b0, x_q} <= paddle_hi)
               dy_d = 1'b0;
            else if (dy_q && y_q == Y_MAX) begin
               state_d = S_LOST;
               miss_d  = 1'b1;
               x_d     = 9'(BALL_X0);
               y_d     = 8'(BALL_Y0);
            end
         end
         S_CHK_BRICK0: state_d = S_CHK_BRICK1;
         S_CHK_BRICK1: state_d = S_CHK_BRICK2;
         // the move lands on this edge so fps is high during MOVE
         S_CHK_BRICK2: begin
            x_d         = cx;
            y_d         = dy_d ? y_q + 8'd1 : y_q - 8'd1;
            fps_d       = 1'b1;
            brick_hit_d = hit_d;
            state_d     = S_MOVE;
         end
         S_MOVE: begin
            cleared_d = alive_q == 3'b000;
            state_d   = alive_q == 3'b000 ? S_DONE : S_WAIT_TICK;
         end
         S_LOST: state_d = S_IDLE;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         x_q         <= 9'(BALL_X0);
         y_q         <= 8'(BALL_Y0);
         dx_q        <= 1'b1;
         dy_q        <= 1'b0;
         pend_q      <= 1'b0;
         hit_q       <= 1'b0;
         bx_q        <= '0;
         by_q        <= '0;
         alive_q     <= 3'b111;
         fps_q       <= 1'b0;
         brick_hit_q <= 1'b0;
         miss_q      <= 1'b0;
         cleared_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         pend_q      <= pend_d;
         hit_q       <= hit_d;
         bx_q        <= bx_d;
         by_q        <= by_d;
         alive_q     <= alive_d;
         fps_q       <= fps_d;
         brick_hit_q <= brick_hit_d;
         miss_q      <= miss_d;
         cleared_q   <= cleared_d;
      end
   end

   assign ball_x       = x_q;
   assign ball_y       = y_q;
   assign fps          = fps_q;
   assign brick_hit    = brick_hit_q;
   assign brick_x      = bx_q;
   assign brick_y      = by_q;
   assign bricks_alive = alive_q;
   assign miss         = miss_q;
   assign cleared      = cleared_q;
endmodule

// File: tb/tb_ball_physics.sv
// tb_ball_physics: randomized paddle play checked tick by tick against a
// plain-integer game model, including mid-tick reset and the cleared end state.
module tb_ball_physics;
   localparam int TD = 16;
   localparam int BX [3] = '{100, 150, 200};
   logic       clk = 1'b0, reset = 1'b0, launch = 1'b0;
   logic [8:0] paddle_pos = '0;
   logic [8:0] ball_x, brick_x;
   logic [7:0] ball_y, brick_y;
   logic       fps, brick_hit, miss, cleared;
   logic [2:0] bricks_alive;
   int         n_chk = 0, n_fail = 0;
   int         mx, my, mdx, mdy, hx, hy;
   bit         alive [3];
   bit         playing, done;

   ball_physics #(.TICK_DIV(TD), .BALL_X0(160), .BALL_Y0(200)) dut (
      .clk         (clk),
      .reset       (reset),
      .launch      (launch),
      .paddle_pos  (paddle_pos),
      .ball_x      (ball_x),
      .ball_y      (ball_y),
      .fps         (fps),
      .brick_hit   (brick_hit),
      .brick_x     (brick_x),
      .brick_y     (brick_y),
      .bricks_alive(bricks_alive),
      .miss        (miss),
      .cleared     (cleared)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_x"}, ball_x, 160);
      chk({tag, "_y"}, ball_y, 200);
      chk({tag, "_fps"}, fps, 0);
      chk({tag, "_brick_hit"}, brick_hit, 0);
      chk({tag, "_miss"}, miss, 0);
      chk({tag, "_cleared"}, cleared, 0);
      chk({tag, "_brick_x"}, brick_x, 0);
      chk({tag, "_brick_y"}, brick_y, 0);
      chk({tag, "_alive"}, bricks_alive, 7);
   endtask

   // one frame tick of the game, straight from the collision rules
   task automatic m_tick(input int p, output bit f, output bit m, output bit h);
      int cx, cy;
      f = 0;
      m = 0;
      h = 0;
      if (!playing || done) return;
      if ((mdx < 0 && mx == 8) || (mdx > 0 && mx == 311)) mdx = -mdx;
      if (mdy < 0 && my == 8) mdy = 1;
      if (mdy > 0 && my == 219 && mx >= p && mx <= p + 31) mdy = -1;
      else if (mdy > 0 && my == 239) begin
         m = 1;
         mx = 160;
         my = 200;
         playing = 0;
         return;
      end
      for (int k = 0; k < 3; k++) begin
         cx = mx + mdx;
         cy = my + mdy;
         if (alive[k] && !h && cx >= BX[k] && cx <= BX[k] + 31 && cy >= 60 && cy <= 63) begin
            alive[k] = 0;
            mdy = -mdy;
            h = 1;
            hx = BX[k];
            hy = 60;
         end
      end
      mx += mdx;
      my += mdy;
      f = 1;
      if (!(alive[0] || alive[1] || alive[2])) done = 1;
   endtask

   task automatic pick_paddle();
      int p;
      p = int'($urandom_range(0, 511));
      if (playing && !done && mdy > 0 && my == 219) begin
         if ($urandom_range(0, 7) != 0) p = mx - int'($urandom_range(0, (mx < 31) ? mx : 31));
         else if (mx >= 40 && $urandom_range(0, 1) == 1) p = mx - 32 - int'($urandom_range(0, 8));
         else p = mx + 1 + int'($urandom_range(0, 8));
      end
      paddle_pos = 9'(p);
   endtask

   // releases reset with launch held and aligns the bench to the first tick edge
   task automatic start_game();
      @(negedge clk);
      check_reset_vals("rst");
      launch = 1'b1;
      reset = 1'b1;
      mx = 160;
      my = 200;
      mdx = 1;
      mdy = -1;
      hx = 0;
      hy = 0;
      alive = '{1, 1, 1};
      playing = 1;
      done = 0;
      for (int k = 1; k <= TD; k++) begin
         @(negedge clk);
         chk("sync_fps", fps, 0);
      end
   endtask

   task automatic run_tick();
      bit f, m, h;
      launch = 1'($urandom_range(0, 1));
      m_tick(int'(paddle_pos), f, m, h);
      for (int k = 1; k <= TD; k++) begin
         @(negedge clk);
         chk("fps", fps, k == 6 && f);
         chk("brick_hit", brick_hit, k == 6 && h);
         chk("miss", miss, k == 3 && m);
         if (k == 3 && m) begin
            chk("miss_x", ball_x, 160);
            chk("miss_y", ball_y, 200);
            launch = 1'b1;
         end
         if (k == 6 && f) begin
            chk("ball_x", ball_x, mx);
            chk("ball_y", ball_y, my);
         end
         if (k == 6 && h) begin
            chk("brick_x", brick_x, hx);
            chk("brick_y", brick_y, hy);
         end
         if (k == 8) pick_paddle();
         if (k == 10) begin
            chk("alive", bricks_alive, {alive[2], alive[1], alive[0]});
            chk("cleared", cleared, done);
            chk("hold_x", ball_x, mx);
            chk("hold_y", ball_y, my);
         end
      end
      if (m) begin
         playing = 1;
         mdx = 1;
         mdy = -1;
      end
   endtask

   // reset pulled during CHK_BRICK1 of a tick
   task automatic mid_reset();
      for (int k = 1; k <= 4; k++) @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_vals("mid");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("mid_fps", fps, 0);
         chk("mid_brick_hit", brick_hit, 0);
      end
      start_game();
   endtask

   initial begin
      int  ticks;
      int  done_ticks;
      bit  mid_done;
      ticks = 0;
      done_ticks = 0;
      mid_done = 0;
      paddle_pos = 9'($urandom_range(0, 511));
      repeat (3) @(negedge clk);
      start_game();
      while (ticks < 4000 && done_ticks < 20) begin
         run_tick();
         ticks++;
         if (done) done_ticks++;
         if (!mid_done && !done && !(alive[0] && alive[1] && alive[2])) begin
            mid_reset();
            mid_done = 1;
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
